// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the 7x7 convolution window feeder.
package conv_pkg;
  localparam int K     = 7;
  localparam int NUM   = K * K;
  localparam int IMA   = 8;
  localparam int DATA  = 16;
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOADW = 2'd1,
    ST_RUN   = 2'd2
  } state_t;
endpackage

// File: rtl/conv_line_buf.sv
// Six circular line buffers sharing one column address. Slot k holds row y-1-k,
// so every accepted pixel cascades one row down the stack at the same column.
module conv_line_buf #(
  parameter int IMA   = 8,
  parameter int MAX_W = 64,
  parameter int ROWS  = 6,
  parameter int AW    = $clog2(MAX_W)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AW-1:0]       addr,
  input  logic [IMA-1:0]      din,
  output logic [IMA*ROWS-1:0] dout
);
  logic [IMA-1:0] mem [ROWS][MAX_W];

  // Reads see the pre-write contents, giving rows y-6..y-1 at column addr.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[0][addr] <= din;
      for (int k = 1; k < ROWS; k++) begin
        mem[k][addr] <= mem[k-1][addr];
      end
    end
  end

  always_comb begin
    dout = '0;
    for (int k = 0; k < ROWS; k++) begin
      dout[k*IMA +: IMA] = mem[k][addr];
    end
  end
endmodule

// File: rtl/conv_feeder.sv
// Streams a raster image into a sliding 7x7 window for a convolution core,
// after optionally loading a 49-tap weight bank and bias.
module conv_feeder #(
  parameter int IMA   = conv_pkg::IMA,
  parameter int DATA  = conv_pkg::DATA,
  parameter int NUM   = conv_pkg::NUM,
  parameter int MAX_W = conv_pkg::MAX_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                cfg_load_w,
  input  logic [6:0]          cfg_width,
  input  logic [6:0]          cfg_height,
  input  logic                wload_valid,
  input  logic [DATA-1:0]     wload_data,
  output logic                wload_ready,
  input  logic                pix_valid,
  input  logic [IMA-1:0]      pix_data,
  output logic                pix_ready,
  output logic [DATA*NUM-1:0] wei,
  output logic [DATA-1:0]     bias,
  output logic [IMA*NUM-1:0]  ima,
  output logic                enable,
  output logic                busy,
  output logic                frame_done,
  output logic [1:0]          dbg_state
);
  import conv_pkg::*;

  localparam int AW = $clog2(MAX_W);

  // Handshakes: a word/pixel transfers on a rising edge where valid and ready
  // are both high; ready depends only on state, never on valid.
  state_t              state;
  logic [6:0]          w_cfg, h_cfg;
  logic [6:0]          x, y;
  logic [5:0]          wcnt;
  logic [IMA*(K-1)-1:0] lb_out;
  logic [IMA-1:0]      new_col [K];
  logic                cfg_ok;
  logic                pix_acc;

  assign cfg_ok      = (cfg_width >= 7'd7) && (int'(cfg_width) <= MAX_W) && (cfg_height >= 7'd7);
  assign pix_acc     = (state == ST_RUN) && pix_valid;
  assign wload_ready = (state == ST_LOADW);
  assign pix_ready   = (state == ST_RUN);
  assign busy        = (state != ST_IDLE);
  assign dbg_state   = state;

  conv_line_buf #(
    .IMA   (IMA),
    .MAX_W (MAX_W),
    .ROWS  (K-1),
    .AW    (AW)
  ) u_line_buf (
    .clk   (clk),
    .wr_en (pix_acc),
    .addr  (x[AW-1:0]),
    .din   (pix_data),
    .dout  (lb_out)
  );

  // Row 0 of the new column is the oldest line (y-6), held in the deepest slot.
  always_comb begin
    for (int r = 0; r < K-1; r++) begin
      new_col[r] = lb_out[(K-2-r)*IMA +: IMA];
    end
    new_col[K-1] = pix_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      w_cfg      <= '0;
      h_cfg      <= '0;
      x          <= '0;
      y          <= '0;
      wcnt       <= '0;
      wei        <= '0;
      bias       <= '0;
      ima        <= '0;
      enable     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      enable     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && cfg_ok) begin
            w_cfg <= cfg_width;
            h_cfg <= cfg_height;
            x     <= '0;
            y     <= '0;
            wcnt  <= '0;
            state <= cfg_load_w ? ST_LOADW : ST_RUN;
          end
        end
        ST_LOADW: begin
          if (wload_valid) begin
            if (int'(wcnt) == NUM) begin
              bias  <= wload_data;
              state <= ST_RUN;
            end else begin
              wei[int'(wcnt)*DATA +: DATA] <= wload_data;
              wcnt <= wcnt + 6'd1;
            end
          end
        end
        ST_RUN: begin
          if (pix_valid) begin
            for (int r = 0; r < K; r++) begin
              for (int c = 0; c < K-1; c++) begin
                ima[(r*K+c)*IMA +: IMA] <= ima[(r*K+c+1)*IMA +: IMA];
              end
              ima[(r*K+K-1)*IMA +: IMA] <= new_col[r];
            end
            // Columns 0..5 of a row would mix pixels from the previous row.
            enable <= (x >= 7'd6) && (y >= 7'd6);
            if (x == w_cfg - 7'd1) begin
              x <= '0;
              if (y == h_cfg - 7'd1) begin
                y          <= '0;
                frame_done <= 1'b1;
                state      <= ST_IDLE;
              end else begin
                y <= y + 7'd1;
              end
            end else begin
              x <= x + 7'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/conv_feeder.md
CONV_FEEDER -- requirements
Module: conv_feeder

Interface
REQ-001 Parameter IMA, default 8, pixel width in bits.
REQ-002 Parameter DATA, default 16, weight/bias width in bits.
REQ-003 Parameter NUM, default 49, taps per window (7x7).
REQ-004 Parameter MAX_W, default 64, maximum image width in pixels.
REQ-005 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  start  in  1  one-cycle frame start request
  cfg_load_w  in  1  sampled with start; 1 = reload weights before streaming
  cfg_width  in  7  image width W, sampled with start
  cfg_height  in  7  image height H, sampled with start
  wload_valid  in  1  weight word valid
  wload_data  in  DATA  weight/bias word
  wload_ready  out  1  weight word accepted when valid&ready
  pix_valid  in  1  pixel valid
  pix_data  in  IMA  pixel, raster order
  pix_ready  out  1  pixel accepted when valid&ready
  wei  out  DATA*NUM  weight bank; tap n at [DATA*(n+1)-1:DATA*n]
  bias  out  DATA  bias word
  ima  out  IMA*NUM  window; tap n=r*7+c at [IMA*(n+1)-1:IMA*n], r=0 top row, c=0 left column
  enable  out  1  one-cycle window-valid strobe to the convolution core
  busy  out  1  high outside IDLE
  frame_done  out  1  one-cycle pulse at end of frame

Function
REQ-006 FSM states: IDLE, LOADW, RUN.
REQ-007 IDLE: on start with 7<=cfg_width<=MAX_W and cfg_height>=7, latch config, go LOADW if cfg_load_w else RUN; an out-of-range start SHALL be ignored.
REQ-008 start outside IDLE SHALL be ignored.
REQ-009 LOADW: wload_ready=1; accepted words 0..48 SHALL write wei tap 0..48, word 49 SHALL write bias, then go RUN the next cycle.
REQ-010 wei and bias SHALL hold their values across frames and change only in LOADW.
REQ-011 RUN: pix_ready=1 (no backpressure); column x counts 0..W-1, row y counts 0..H-1 per accepted pixel.
REQ-012 Six circular line buffers (MAX_W x IMA each) SHALL supply the pixel at column x of rows y-6..y-1.
REQ-013 Each accepted pixel SHALL shift the 7x7 window one column left; the new column c=6 SHALL be rows y-6..y-1 from the line buffers plus the new pixel at r=6.
REQ-014 enable SHALL pulse exactly one cycle after acceptance of pixel (x,y) with x>=6 and y>=6; ima SHALL then hold that window, stable until the next accepted pixel.
REQ-015 A frame SHALL produce exactly (W-6)*(H-6) enable pulses.
REQ-016 After pixel (W-1,H-1) is accepted: frame_done SHALL pulse in the same cycle as the last enable, and the FSM SHALL return to IDLE.
REQ-017 Window contents straddling a row wrap SHALL never be flagged by enable.
REQ-018 wload_ready=0 outside LOADW; pix_ready=0 outside RUN.

Reset
REQ-019 rst_n low SHALL force IDLE, with enable=0, frame_done=0, busy=0, wload_ready=0, pix_ready=0, wei=0, bias=0, ima=0, and counters=0.
REQ-020 Reset mid-LOADW or mid-RUN SHALL abort the frame with no further enable pulses; line-buffer contents need not be cleared.

Structure
REQ-021 Shared package conv_pkg SHALL hold K=7, NUM, IMA, DATA, MAX_W, and the FSM state enum.
REQ-022 A sub-module conv_line_buf SHALL implement the six circular line buffers with a shared column address.

Verification
REQ-023 Load words 1..49 and bias 0x8000 -> wei tap n = n+1, bias=0x8000, and RUN is entered one cycle after word 49.
REQ-024 W=7, H=7, pixels 0..48 -> exactly one enable, one cycle after pixel 48, with ima tap n = n, and frame_done coincident with it.
REQ-025 W=8, H=8, pixel=(8y+x) -> 4 enables; the first has tap0=0 and tap48=54, the last has tap0=9 and tap48=63.
REQ-026 Second frame with cfg_load_w=0 -> wei and bias are unchanged, and the frame goes directly to RUN.
REQ-027 start with cfg_width=6, or start while busy -> ignored, state unchanged.
REQ-028 rst_n low after 20 pixels of an 8x8 frame -> all outputs 0, and a fresh 7x7 frame then yields a correct single enable.
